// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg
// Shared definitions for the LCD command sequencer:
//   - state_t      : sequencer states (ST_INIT exists only with LCD_SEQ_INIT_EN)
//   - DEF_*        : default cycle counts for the timing parameters
//   - CMD_*        : HD44780 power-on command bytes sent by the init ROM
//   - is_clear_home: decode for the slow clear/home commands
//   - at_least_one : maps a zero cycle count to one so no state is skipped
// Optional feature macro: LCD_SEQ_INIT_EN (adds the autonomous power-on INIT state).
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
`ifdef LCD_SEQ_INIT_EN
    ,
    ST_INIT  = 3'd5
`endif
  } state_t;

  localparam int DEF_SETUP_CYCLES      = 2;
  localparam int DEF_E_CYCLES          = 12;
  localparam int DEF_HOLD_CYCLES       = 2;
  localparam int DEF_EXEC_CYCLES       = 1850;
  localparam int DEF_CLEAR_EXEC_CYCLES = 76000;
  localparam int DEF_INIT_WAIT_CYCLES  = 750000;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam int         INIT_CMD_COUNT   = 4;

  // Clear display (0x01) and return home (0x02/0x03) are the only commands
  // with the long execution time.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

  function automatic int at_least_one(input int cycles);
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// lcd_seq_timer
// Shared down-counter for the sequencer. A state lasts value+1 cycles when
// the counter is loaded with value on entry; done is high while the count
// is zero, and the count saturates there instead of wrapping.
// Ports:
//   clk, reset : clock and synchronous active-high reset (count <= RESET_VALUE)
//   load       : load value into the counter (has priority over tick)
//   value      : count to load
//   tick       : decrement by one while nonzero
//   done       : count has reached zero
module lcd_seq_timer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= value;
    end else if (tick && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// Turns a byte handshake into timed HD44780 bus writes through an Avalon-MM
// style LCD slave: SETUP (RS/RW settle), PULSE (write strobe drives E),
// HOLD (address/data held after E falls), EXEC (controller busy time).
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_valid/in_ready   : byte handshake, accepted only in IDLE
//   in_rs, in_data      : 0 = command, 1 = character data; byte to send
//   busy                : high in every state except IDLE
//   avm_address         : {RS, RW}, RW always 0
//   avm_write           : write strobe, high for the whole PULSE state
//   avm_read            : tied low
//   avm_begintransfer   : one-cycle pulse in the first PULSE cycle
//   avm_writedata       : byte on the LCD bus
// Optional feature macro: LCD_SEQ_INIT_EN -- after reset, wait
// INIT_WAIT_CYCLES and send 0x38, 0x0C, 0x01, 0x06 before accepting bytes.
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int SETUP_CYCLES      = DEF_SETUP_CYCLES,
  parameter int E_CYCLES          = DEF_E_CYCLES,
  parameter int HOLD_CYCLES       = DEF_HOLD_CYCLES,
  parameter int EXEC_CYCLES       = DEF_EXEC_CYCLES,
  parameter int CLEAR_EXEC_CYCLES = DEF_CLEAR_EXEC_CYCLES,
  parameter int INIT_WAIT_CYCLES  = DEF_INIT_WAIT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic [1:0] avm_address,
  output logic       avm_write,
  output logic       avm_read,
  output logic       avm_begintransfer,
  output logic [7:0] avm_writedata
);

  localparam int SETUP_N = at_least_one(SETUP_CYCLES);
  localparam int E_N     = at_least_one(E_CYCLES);
  localparam int HOLD_N  = at_least_one(HOLD_CYCLES);
  localparam int EXEC_N  = at_least_one(EXEC_CYCLES);
  localparam int CLEAR_N = at_least_one(CLEAR_EXEC_CYCLES);
  localparam int INIT_N  = at_least_one(INIT_WAIT_CYCLES);

  localparam int MAX_A = (SETUP_N > E_N) ? SETUP_N : E_N;
  localparam int MAX_B = (HOLD_N > EXEC_N) ? HOLD_N : EXEC_N;
  localparam int MAX_C = (CLEAR_N > INIT_N) ? CLEAR_N : INIT_N;
  localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_N = (MAX_C > MAX_D) ? MAX_C : MAX_D;
  localparam int CNT_W = $clog2(MAX_N) + 1;

  // A state lasts load+1 cycles, so each load is one less than its length.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] E_LOAD     = CNT_W'(E_N - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_N - 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_N - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_N - 1);

`ifdef LCD_SEQ_INIT_EN
  // The power-on wait is timed by the shared counter straight out of reset.
  localparam logic [CNT_W-1:0] TIMER_RESET = CNT_W'(INIT_N - 1);
  localparam state_t           RESET_STATE = ST_INIT;
  localparam logic [1:0]       LAST_INIT   = 2'(INIT_CMD_COUNT - 1);

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNCTION_SET;
      2'd1:    return CMD_DISPLAY_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY_MODE;
    endcase
  endfunction

  logic [1:0] init_idx;
  logic       init_run;
`else
  localparam logic [CNT_W-1:0] TIMER_RESET = '0;
  localparam state_t           RESET_STATE = ST_IDLE;
`endif

  state_t           state;
  logic             accept;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_tick;
  logic             tmr_done;

  assign accept   = (state == ST_IDLE) && in_ready && in_valid;
  assign tmr_tick = (state != ST_IDLE);
  assign avm_read = 1'b0;

  lcd_seq_timer #(
    .WIDTH       (CNT_W),
    .RESET_VALUE (TIMER_RESET)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .tick  (tmr_tick),
    .done  (tmr_done)
  );

  // Reload the shared counter on every state entry with the new state's length.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tmr_load  = 1'b1;
          tmr_value = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = E_LOAD;
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = is_clear_home(avm_address[1], avm_writedata) ? CLEAR_LOAD : EXEC_LOAD;
        end
      end
`ifdef LCD_SEQ_INIT_EN
      ST_EXEC: begin
        if (tmr_done && init_run && (init_idx != LAST_INIT)) begin
          tmr_load  = 1'b1;
          tmr_value = SETUP_LOAD;
        end
      end
      ST_INIT: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = SETUP_LOAD;
        end
      end
`endif
      default: begin
        tmr_load  = 1'b0;
        tmr_value = '0;
      end
    endcase
  end

  // Main sequencer. Address and data are captured on entry to SETUP and left
  // untouched until the next accept, so they stay stable through EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RESET_STATE;
      in_ready          <= 1'b0;
      busy              <= 1'b1;
      avm_write         <= 1'b0;
      avm_begintransfer <= 1'b0;
      avm_address       <= 2'b00;
      avm_writedata     <= 8'h00;
`ifdef LCD_SEQ_INIT_EN
      init_idx          <= 2'd0;
      init_run          <= 1'b1;
`endif
    end else begin
      avm_begintransfer <= 1'b0;
      case (state)
`ifdef LCD_SEQ_INIT_EN
        ST_INIT: begin
          if (tmr_done) begin
            state         <= ST_SETUP;
            avm_address   <= 2'b00;
            avm_writedata <= init_rom(2'd0);
          end
        end
`endif
        ST_IDLE: begin
          if (accept) begin
            state         <= ST_SETUP;
            avm_address   <= {in_rs, 1'b0};
            avm_writedata <= in_data;
            in_ready      <= 1'b0;
            busy          <= 1'b1;
          end else begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state             <= ST_PULSE;
            avm_write         <= 1'b1;
            avm_begintransfer <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (tmr_done) begin
            state     <= ST_HOLD;
            avm_write <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (tmr_done) begin
`ifdef LCD_SEQ_INIT_EN
            if (init_run && (init_idx != LAST_INIT)) begin
              init_idx      <= init_idx + 2'd1;
              avm_writedata <= init_rom(init_idx + 2'd1);
              state         <= ST_SETUP;
            end else begin
              init_run <= 1'b0;
              state    <= ST_IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
`else
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer
// Directed bench for lcd_cmd_sequencer. The main instance uses shortened
// execution times so the slow clear/home path stays short; a second instance
// sets every cycle count to zero so each state must last exactly one cycle.
// With LCD_SEQ_INIT_EN defined the power-on command burst is also checked.
module tb_lcd_cmd_sequencer;

  localparam int S  = 2;
  localparam int E  = 12;
  localparam int H  = 2;
  localparam int X  = 20;
  localparam int XC = 60;
  localparam int IW = 10;
  localparam int PERIOD_CYC = S + E + H + X + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic [1:0] avm_address;
  logic       avm_write;
  logic       avm_read;
  logic       avm_begintransfer;
  logic [7:0] avm_writedata;

  logic       z_in_valid;
  logic       z_in_rs;
  logic [7:0] z_in_data;
  logic       z_in_ready;
  logic       z_busy;
  logic [1:0] z_avm_address;
  logic       z_avm_write;
  logic       z_avm_read;
  logic       z_avm_begintransfer;
  logic [7:0] z_avm_writedata;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [7:0] pulse_data [$];
  logic [1:0] pulse_addr [$];
  int         pulse_start[$];
  logic       prev_write = 1'b0;

  lcd_cmd_sequencer #(
    .SETUP_CYCLES      (S),
    .E_CYCLES          (E),
    .HOLD_CYCLES       (H),
    .EXEC_CYCLES       (X),
    .CLEAR_EXEC_CYCLES (XC),
    .INIT_WAIT_CYCLES  (IW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_rs             (in_rs),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .busy              (busy),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_begintransfer (avm_begintransfer),
    .avm_writedata     (avm_writedata)
  );

  lcd_cmd_sequencer #(
    .SETUP_CYCLES      (0),
    .E_CYCLES          (0),
    .HOLD_CYCLES       (0),
    .EXEC_CYCLES       (0),
    .CLEAR_EXEC_CYCLES (0),
    .INIT_WAIT_CYCLES  (0)
  ) dut_zero (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (z_in_valid),
    .in_rs             (z_in_rs),
    .in_data           (z_in_data),
    .in_ready          (z_in_ready),
    .busy              (z_busy),
    .avm_address       (z_avm_address),
    .avm_write         (z_avm_write),
    .avm_read          (z_avm_read),
    .avm_begintransfer (z_avm_begintransfer),
    .avm_writedata     (z_avm_writedata)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Log every rising edge of the write strobe with the byte it carried.
  always @(negedge clk) begin
    if (avm_write === 1'b1 && prev_write !== 1'b1) begin
      pulse_data.push_back(avm_writedata);
      pulse_addr.push_back(avm_address);
      pulse_start.push_back(cyc);
    end
    prev_write = avm_write;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  // Leaves the bench at a falling edge with in_ready high, or records a timeout.
  task automatic waitReady(input string tag, input int max_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  // Sends one byte and checks the full SETUP/PULSE/HOLD/EXEC timeline.
  task automatic applyStimulus(input logic rs, input logic [7:0] data, input int exec_len, input string tag);
    int first_w, n_w, bt_at, n_bt, ready_at, bad_addr, bad_data, bad_busy, busy_at_ready, limit;
    first_w = -1; n_w = 0; bt_at = -1; n_bt = 0; ready_at = -1;
    bad_addr = 0; bad_data = 0; bad_busy = 0; busy_at_ready = -1;
    waitReady({tag, "_ready"}, 2000);
    in_rs    = rs;
    in_data  = data;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    limit = S + E + H + exec_len + 20;
    for (int k = 1; k <= limit && ready_at < 0; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ready_at      = k;
        busy_at_ready = int'(busy);
      end else begin
        if (avm_address !== {rs, 1'b0}) bad_addr++;
        if (avm_writedata !== data) bad_data++;
        if (busy !== 1'b1) bad_busy++;
        if (avm_write === 1'b1) begin
          if (first_w < 0) first_w = k;
          n_w++;
        end
        if (avm_begintransfer === 1'b1) begin
          if (bt_at < 0) bt_at = k;
          n_bt++;
        end
      end
    end
    checkOutput({tag, "_write_start"}, first_w, S + 1);
    checkOutput({tag, "_write_width"}, n_w, E);
    checkOutput({tag, "_begin_cycle"}, bt_at, S + 1);
    checkOutput({tag, "_begin_count"}, n_bt, 1);
    checkOutput({tag, "_ready_return"}, ready_at, S + E + H + exec_len + 1);
    checkOutput({tag, "_busy_at_ready"}, busy_at_ready, 0);
    checkOutput({tag, "_addr_unstable"}, bad_addr, 0);
    checkOutput({tag, "_data_unstable"}, bad_data, 0);
    checkOutput({tag, "_busy_dropped"}, bad_busy, 0);
  endtask

  initial begin
    int base, a1, a2, n, resent;
    logic [3:0] zexp [5];
    logic [7:0] init_exp [4];
    zexp[0] = 4'b0100;
    zexp[1] = 4'b0111;
    zexp[2] = 4'b0100;
    zexp[3] = 4'b0100;
    zexp[4] = 4'b1000;
    init_exp[0] = 8'h38;
    init_exp[1] = 8'h0C;
    init_exp[2] = 8'h01;
    init_exp[3] = 8'h06;

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_rs      = 1'b0;
    in_data    = 8'h00;
    z_in_valid = 1'b0;
    z_in_rs    = 1'b0;
    z_in_data  = 8'h00;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    checkOutput("rst_write", int'(avm_write), 0);
    checkOutput("rst_begin", int'(avm_begintransfer), 0);
    checkOutput("rst_addr", int'(avm_address), 0);
    checkOutput("rst_data", int'(avm_writedata), 0);
    checkOutput("rst_ready", int'(in_ready), 0);
    checkOutput("rst_busy", int'(busy), 1);
    checkOutput("rst_read", int'(avm_read), 0);
    reset = 1'b0;
    @(negedge clk);
`ifdef LCD_SEQ_INIT_EN
    checkOutput("rel_ready", int'(in_ready), 0);
    checkOutput("rel_busy", int'(busy), 1);
    base = pulse_data.size();
    n = 0;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("init_ready_seen", int'(in_ready), 1);
    checkOutput("init_pulse_count", pulse_data.size() - base, 4);
    checkOutput("init_first_pulse_after_wait", (pulse_start.size() > base) ? int'(pulse_start[base] >= IW) : 0, 1);
    for (int i = 0; i < 4; i++) begin
      if (pulse_data.size() > base + i) begin
        checkOutput($sformatf("init_cmd%0d_data", i), int'(pulse_data[base + i]), int'(init_exp[i]));
        checkOutput($sformatf("init_cmd%0d_addr", i), int'(pulse_addr[base + i]), 0);
      end
    end
`else
    checkOutput("rel_ready", int'(in_ready), 1);
    checkOutput("rel_busy", int'(busy), 0);
`endif

    // Zero cycle counts: every state lasts exactly one cycle.
    n = 0;
    while (z_in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("zero_ready", int'(z_in_ready), 1);
    z_in_rs    = 1'b1;
    z_in_data  = 8'h33;
    z_in_valid = 1'b1;
    @(posedge clk);
    #1;
    z_in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("zero_cycle%0d_flags", k + 1),
                  int'({z_in_ready, z_busy, z_avm_write, z_avm_begintransfer}), int'(zexp[k]));
      if (k == 1) begin
        checkOutput("zero_pulse_data", int'(z_avm_writedata), 8'h33);
        checkOutput("zero_pulse_addr", int'(z_avm_address), 2);
      end
    end

    // Single transfers, including both sides of the clear/home decode.
    applyStimulus(1'b1, 8'h41, X,  "char41");
    applyStimulus(1'b0, 8'h01, XC, "clear01");
    applyStimulus(1'b0, 8'h80, X,  "ddram80");
    applyStimulus(1'b0, 8'h02, XC, "home02");
    applyStimulus(1'b0, 8'h04, X,  "entry04");
    applyStimulus(1'b1, 8'h01, X,  "char01");

    // Back-to-back: in_valid stays high across two bytes.
    waitReady("b2b_ready", 2000);
    base     = pulse_data.size();
    in_rs    = 1'b1;
    in_data  = 8'h48;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a1      = cyc;
    in_data = 8'h49;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < PERIOD_CYC + 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) checkOutput("b2b_second_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    a2       = cyc;
    in_valid = 1'b0;
    waitReady("b2b_done", 2000);
    checkOutput("b2b_accept_gap", a2 - a1, PERIOD_CYC);
    checkOutput("b2b_pulse_count", pulse_data.size() - base, 2);
    if (pulse_data.size() >= base + 2) begin
      checkOutput("b2b_first_byte", int'(pulse_data[base]), 8'h48);
      checkOutput("b2b_second_byte", int'(pulse_data[base + 1]), 8'h49);
      checkOutput("b2b_first_latency", pulse_start[base] - a1, S);
      checkOutput("b2b_pulse_spacing", pulse_start[base + 1] - pulse_start[base], PERIOD_CYC);
    end

    // Reset in the fifth PULSE cycle.
    waitReady("rstp_ready", 2000);
    base     = pulse_data.size();
    in_rs    = 1'b1;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (S + 5) @(negedge clk);
    checkOutput("rstp_write_before", int'(avm_write), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstp_write_after", int'(avm_write), 0);
    checkOutput("rstp_begin_after", int'(avm_begintransfer), 0);
    checkOutput("rstp_ready_after", int'(in_ready), 0);
    checkOutput("rstp_busy_after", int'(busy), 1);
    checkOutput("rstp_addr_after", int'(avm_address), 0);
    checkOutput("rstp_data_after", int'(avm_writedata), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`ifndef LCD_SEQ_INIT_EN
    checkOutput("rstp_idle_ready", int'(in_ready), 1);
    checkOutput("rstp_idle_busy", int'(busy), 0);
`endif
    waitReady("rstp_recover", 2000);
    repeat (2 * PERIOD_CYC) @(negedge clk);
    resent = 0;
    for (int i = base + 1; i < pulse_data.size(); i++) begin
      if (pulse_data[i] == 8'h5A) resent++;
    end
    checkOutput("rstp_no_resend", resent, 0);
`ifdef LCD_SEQ_INIT_EN
    checkOutput("rstp_pulse_total", pulse_data.size() - base, 5);
`else
    checkOutput("rstp_pulse_total", pulse_data.size() - base, 1);
`endif
    checkOutput("rstp_read_low", int'(avm_read), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SETUP_CYCLES, 2: RS/RW setup before E.
- E_CYCLES, 12: E (write) high width.
- HOLD_CYCLES, 2: address/data hold after E falls.
- EXEC_CYCLES, 1850: wait after a normal command or data byte.
- CLEAR_EXEC_CYCLES, 76000: wait after clear/home.
- INIT_WAIT_CYCLES, 750000: power-on wait.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: byte offered.
- in_rs, in, 1: 0 = command, 1 = character data.
- in_data, in, 8: byte to send.
- in_ready, out, 1: sequencer can accept.
- busy, out, 1: transfer or execution wait in progress.
- avm_address, out, 2: {RS, RW} to the LCD slave; RW is always 0.
- avm_write, out, 1: write strobe; the slave drives E from it.
- avm_read, out, 1: tied 0.
- avm_begintransfer, out, 1: one-cycle pulse at transfer start.
- avm_writedata, out, 8: byte to the LCD bus.

Function
REQ-003 The block SHALL implement states INIT, IDLE, SETUP, PULSE, HOLD and EXEC, with one shared down-counter.
REQ-004 In IDLE, in_ready SHALL be 1; all other states SHALL hold in_ready at 0.
REQ-005 When in_valid and in_ready are both 1, the block SHALL capture in_rs and in_data, load SETUP_CYCLES, and enter SETUP on the next cycle.
REQ-006 From SETUP onward, avm_address SHALL equal {captured rs, 1'b0} and avm_writedata SHALL equal the captured byte; both SHALL be stable until EXEC ends.
REQ-007 SETUP SHALL last exactly SETUP_CYCLES cycles with avm_write=0, then the block SHALL enter PULSE.
REQ-008 PULSE SHALL hold avm_write=1 for exactly E_CYCLES cycles, and avm_begintransfer SHALL be 1 only in the first PULSE cycle.
REQ-009 HOLD SHALL last HOLD_CYCLES cycles with avm_write=0, then the block SHALL enter EXEC.
REQ-010 EXEC SHALL wait CLEAR_EXEC_CYCLES when rs=0, data[7:2]=0 and data!=0 (clear/home); otherwise it SHALL wait EXEC_CYCLES, then return to IDLE.
REQ-011 Any cycle parameter set to 0 SHALL be treated as 1, so every state lasts at least one cycle.
REQ-012 The counter width SHALL be $clog2 of the largest parameter plus 1, and the counter SHALL never wrap.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 in_valid asserted outside IDLE SHALL be ignored; the byte SHALL be taken only once the block is in IDLE.
REQ-015 End-to-end latency from the accept edge to the first avm_write=1 cycle SHALL be SETUP_CYCLES+1 cycles.
REQ-016 Back-to-back bytes SHALL be accepted at most once per SETUP+E+HOLD+EXEC+1 cycles.

Reset
REQ-017 On a clock edge with reset=1, the block SHALL go to its reset values: avm_write=0, avm_begintransfer=0, avm_address=0, avm_writedata=0, in_ready=0, busy=1, and the state SHALL become INIT (if LCD_SEQ_INIT_EN is defined) or IDLE (if not; in_ready=1 and busy=0 the cycle after reset is released).
REQ-018 A reset during PULSE SHALL drop avm_write on that same edge, and the in-flight byte SHALL be discarded.

Configuration
REQ-019 With macro LCD_SEQ_INIT_EN defined, INIT SHALL wait INIT_WAIT_CYCLES and then autonomously send commands 0x38, 0x0C, 0x01, 0x06 (rs=0), each using the full SETUP/PULSE/HOLD/EXEC sequence, before entering IDLE; in_ready SHALL stay 0 throughout.
REQ-020 Without LCD_SEQ_INIT_EN, the INIT state and the init ROM SHALL be absent, and reset SHALL go directly to IDLE.

Structure
REQ-021 Package lcd_seq_pkg SHALL hold the state enum, the init command constants (0x38, 0x0C, 0x01, 0x06), the clear/home decode function, and the default cycle constants.
REQ-022 The down-counter SHALL be a sub-module named lcd_seq_timer, with load, value, tick and done.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Defaults, no macro: send rs=1, data=0x41 -> avm_address=2'b10, avm_writedata=0x41, avm_write high exactly 12 cycles starting 3 cycles after accept, avm_begintransfer high one cycle, in_ready returns after 2+12+2+1850 cycles.
- Send rs=0, data=0x01 -> EXEC lasts 76000 cycles; with data=0x80 -> EXEC lasts 1850 cycles.
- Hold in_valid high with two queued bytes 0x48, 0x49 -> two distinct PULSE windows, separated by at least 1866 cycles; no byte lost or duplicated.
- Assert reset in the 5th PULSE cycle -> avm_write=0 on the next edge, state IDLE, the byte is not resent.
- LCD_SEQ_INIT_EN defined, INIT_WAIT_CYCLES=10 -> after 10 cycles, four PULSEs carry 0x38, 0x0C, 0x01, 0x06 in order with address 2'b00, in_ready=0 until the last EXEC completes.
- SETUP_CYCLES=0, HOLD_CYCLES=0 -> each state lasts exactly 1 cycle.
